// File: rtl/lap_recorder_ctl.sv
// Lap/split controller: records split times, freezes the display for a
// hold window, and steps through stored laps on recall.
//
// Ports:
//   clk, reset (async, active-low)
//   init_regs      : Ctl in IDLE, clears all laps
//   count_enabled  : Ctl in COUNTING, splits only count while set
//   split, recall  : single-cycle event pulses
//   time_in        : live counter value
//   disp_time      : registered display value
//   disp_mode      : 0 LIVE, 1 FROZEN, 2 RECALL
//   lap_count      : stored laps, 0..DEPTH
//   lap_idx        : lap shown in RECALL
//   laps_full      : lap_count == DEPTH
module lap_recorder_ctl #(
  parameter int TIME_W   = 16,
  parameter int DEPTH    = 8,
  parameter int HOLD_CYC = 4,
  parameter int IDX_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_regs,
  input  logic              count_enabled,
  input  logic              split,
  input  logic              recall,
  input  logic [TIME_W-1:0] time_in,
  output logic [TIME_W-1:0] disp_time,
  output logic [1:0]        disp_mode,
  output logic [IDX_W:0]    lap_count,
  output logic [IDX_W-1:0]  lap_idx,
  output logic              laps_full
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYC - 1);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_LIVE   = 2'd0,
    S_FROZEN = 2'd1,
    S_RECALL = 2'd2
  } state_t;

  state_t              state_q;
  logic [TIME_W-1:0]   disp_q;
  logic [IDX_W:0]      cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [HW-1:0]       hold_q;
  logic [TIME_W-1:0]   mem [DEPTH];

  logic                full;
  logic                take_split;
  logic                we;
  logic [IDX_W-1:0]    waddr;
  logic                last_idx;
  logic [IDX_W-1:0]    nidx;

  assign full = (cnt_q == FULL_CNT);

  // A split only records/freezes while counting and outside RECALL.
  assign take_split = split & count_enabled & ~init_regs
                    & (state_q != S_RECALL);
  assign we    = take_split & ~full;
  assign waddr = cnt_q[IDX_W-1:0];

  assign last_idx = ({1'b0, idx_q} == (cnt_q - 1'b1));
  assign nidx     = last_idx ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= time_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LIVE;
      disp_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
    end else if (init_regs) begin
      state_q <= S_LIVE;
      disp_q  <= time_in;
      cnt_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      unique case (state_q)
        S_LIVE: begin
          if (take_split) begin
            state_q <= S_FROZEN;
            disp_q  <= time_in;
            hold_q  <= HOLD_LD;
            if (!full) cnt_q <= cnt_q + 1'b1;
          end else if (recall && cnt_q != '0) begin
            state_q <= S_RECALL;
            idx_q   <= '0;
            disp_q  <= mem[0];
          end else begin
            disp_q  <= time_in;
          end
        end
        S_FROZEN: begin
          if (take_split) begin
            disp_q  <= time_in;
            hold_q  <= HOLD_LD;
            if (!full) cnt_q <= cnt_q + 1'b1;
          end else if (hold_q == '0) begin
            state_q <= S_LIVE;
            disp_q  <= time_in;
          end else begin
            hold_q  <= hold_q - 1'b1;
          end
        end
        S_RECALL: begin
          if (split) begin
            state_q <= S_LIVE;
            disp_q  <= time_in;
          end else if (recall) begin
            idx_q   <= nidx;
            disp_q  <= mem[nidx];
          end
        end
        default: begin
          state_q <= S_LIVE;
        end
      endcase
    end
  end

  assign disp_time = disp_q;
  assign disp_mode = state_q;
  assign lap_count = cnt_q;
  assign lap_idx   = idx_q;
  assign laps_full = full;

endmodule

// File: tb/tb_lap_recorder_ctl.sv
// Bench for lap_recorder_ctl: directed scenarios with literal
// expectations plus randomized traffic against a queue-based model.
module tb_lap_recorder_ctl;

  localparam int TIME_W   = 16;
  localparam int DEPTH    = 8;
  localparam int HOLD_CYC = 4;
  localparam int IDX_W    = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              init_regs = 1'b0;
  logic              count_enabled = 1'b0;
  logic              split = 1'b0;
  logic              recall = 1'b0;
  logic [TIME_W-1:0] time_in = '0;
  logic [TIME_W-1:0] disp_time;
  logic [1:0]        disp_mode;
  logic [IDX_W:0]    lap_count;
  logic [IDX_W-1:0]  lap_idx;
  logic              laps_full;

  int n_chk = 0;
  int n_fail = 0;

  lap_recorder_ctl #(
    .TIME_W(TIME_W), .DEPTH(DEPTH),
    .HOLD_CYC(HOLD_CYC), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(rst_n),
    .init_regs(init_regs),
    .count_enabled(count_enabled),
    .split(split), .recall(recall),
    .time_in(time_in),
    .disp_time(disp_time),
    .disp_mode(disp_mode),
    .lap_count(lap_count),
    .lap_idx(lap_idx),
    .laps_full(laps_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: laps kept as a queue, freeze as a deadline.
  logic [TIME_W-1:0] laps [$];
  int                m_mode = 0;
  int                m_idx = 0;
  logic [TIME_W-1:0] m_disp = '0;
  longint            cyc = 0;
  longint            m_until = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        laps.delete();
        m_mode = 0;
        m_idx  = 0;
        m_disp = '0;
      end else begin
        cyc++;
        if (init_regs) begin
          laps.delete();
          m_mode = 0;
          m_idx  = 0;
          m_disp = time_in;
        end else if (m_mode == 2) begin
          if (split) begin
            m_mode = 0;
            m_disp = time_in;
          end else if (recall) begin
            m_idx  = (m_idx + 1) % laps.size();
            m_disp = laps[m_idx];
          end
        end else if (split && count_enabled) begin
          if (laps.size() < DEPTH) laps.push_back(time_in);
          m_mode  = 1;
          m_disp  = time_in;
          m_until = cyc + HOLD_CYC;
        end else if (m_mode == 1) begin
          if (cyc >= m_until) begin
            m_mode = 0;
            m_disp = time_in;
          end
        end else if (recall && laps.size() > 0) begin
          m_mode = 2;
          m_idx  = 0;
          m_disp = laps[0];
        end else begin
          m_disp = time_in;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("disp_time", 32'(disp_time), 32'(m_disp));
      chk("disp_mode", 32'(disp_mode), 32'(m_mode));
      chk("lap_count", 32'(lap_count), 32'(laps.size()));
      chk("lap_idx",   32'(lap_idx),   32'(m_idx));
      chk("laps_full", 32'(laps_full),
          32'(laps.size() == DEPTH));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_split();
    split = 1'b1;
    tick();
    split = 1'b0;
  endtask

  task automatic clear_laps();
    init_regs = 1'b1;
    tick();
    init_regs = 1'b0;
  endtask

  // Called 1 time unit after a rising edge: reset mid-cycle.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_disp", 32'(disp_time), 32'h0);
    chk("rst_mode", 32'(disp_mode), 32'h0);
    chk("rst_cnt",  32'(lap_count), 32'h0);
    chk("rst_idx",  32'(lap_idx),   32'h0);
    chk("rst_full", 32'(laps_full), 32'h0);
    #3 rst_n = 1'b1;
  endtask

  task automatic record3();
    for (int i = 1; i <= 3; i++) begin
      time_in = 16'(10 * i);
      pulse_split();
      tick();
    end
    repeat (5) tick();
  endtask

  int exp_t [4] = '{10, 20, 30, 10};
  int exp_i [4] = '{0, 1, 2, 0};

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_disp", 32'(disp_time), 32'h0);
    chk("init_mode", 32'(disp_mode), 32'h0);
    chk("init_cnt",  32'(lap_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Split freezes for HOLD_CYC cycles.
    count_enabled = 1'b1;
    time_in = 16'h0123;
    pulse_split();
    chk("t2_mode", 32'(disp_mode), 32'd1);
    chk("t2_disp", 32'(disp_time), 32'h0123);
    chk("t2_cnt",  32'(lap_count), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      time_in = 16'(16'h0123 + k);
      tick();
      chk("t2_hold_mode", 32'(disp_mode), 32'd1);
      chk("t2_hold_disp", 32'(disp_time), 32'h0123);
    end
    time_in = 16'h0200;
    tick();
    chk("t2_live_mode", 32'(disp_mode), 32'd0);
    chk("t2_live_disp", 32'(disp_time), 32'h0200);

    // Split while paused is ignored.
    count_enabled = 1'b0;
    pulse_split();
    chk("t3_mode", 32'(disp_mode), 32'd0);
    chk("t3_cnt",  32'(lap_count), 32'd1);
    clear_laps();
    chk("t3_clr", 32'(lap_count), 32'd0);

    // Nine splits into eight entries.
    count_enabled = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      time_in = 16'(10 * i);
      pulse_split();
      tick();
    end
    chk("t4_cnt",  32'(lap_count), 32'd8);
    chk("t4_full", 32'(laps_full), 32'd1);
    chk("t4_disp", 32'(disp_time), 32'd90);
    chk("t4_mode", 32'(disp_mode), 32'd1);
    repeat (5) tick();
    recall = 1'b1;
    repeat (8) tick();
    recall = 1'b0;
    chk("t4_mem7", 32'(disp_time), 32'd80);
    chk("t4_idx7", 32'(lap_idx),   32'd7);
    pulse_split();
    chk("t4_exit", 32'(disp_mode), 32'd0);
    clear_laps();

    // Recall wraps after the last lap.
    record3();
    for (int k = 0; k < 4; k++) begin
      recall = 1'b1;
      tick();
      recall = 1'b0;
      chk("t5_disp", 32'(disp_time), 32'(exp_t[k]));
      chk("t5_idx",  32'(lap_idx),   32'(exp_i[k]));
      tick();
    end
    pulse_split();
    chk("t5_mode", 32'(disp_mode), 32'd0);
    chk("t5_cnt",  32'(lap_count), 32'd3);
    clear_laps();

    // Priority: split over recall, init over split.
    time_in = 16'h0055;
    split = 1'b1;
    recall = 1'b1;
    tick();
    split = 1'b0;
    recall = 1'b0;
    chk("t6_mode", 32'(disp_mode), 32'd1);
    chk("t6_cnt",  32'(lap_count), 32'd1);
    init_regs = 1'b1;
    split = 1'b1;
    tick();
    init_regs = 1'b0;
    split = 1'b0;
    chk("t6_init_mode", 32'(disp_mode), 32'd0);
    chk("t6_init_cnt",  32'(lap_count), 32'd0);

    // Reset in the middle of a hold.
    pulse_split();
    chk("t1_frozen", 32'(disp_mode), 32'd1);
    async_reset();
    tick();

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) async_reset();
      init_regs = ($urandom_range(0, 79) == 0);
      split     = ($urandom_range(0, 5) == 0);
      recall    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0)
        count_enabled = ~count_enabled;
      if ($urandom_range(0, 3) == 0) time_in = 16'($urandom);
      else time_in = time_in + 16'd1;
      tick();
    end
    init_regs = 1'b0;
    split = 1'b0;
    recall = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
